elpis_test_monitor: RTL
=======================

// Module: elpis_test_monitor
// PURPOSE
// - On-chip self-check monitor in the user project, beside core0. Snoops the register-file
//   write-back port and steps through an ordered list of NUM_CHECKS expected (reg, value) pairs.
// - Has a cycle timeout and publishes a 16-bit status word that drives mprj_io[31:16].
// - Successor to single-register, fixed-timeout checking: depth, data width and timeout are
//   parameters, and the check list is loaded at run time over the LA.
// PARAMETERS
// - XLEN          32   regfile data width
// - NUM_CHECKS     4   depth of the expected-value list (1..16)
// - TIMEOUT_KCYC 100   timeout in units of 1000 clocks; 0 disables the timeout
// PORTS
// - wb_clk_i     in   1                   single clock
// - wb_rst_i     in   1                   synchronous reset, active-high
// - rf_we_i      in   1                   regfile write strobe (core0 write-back)
// - rf_waddr_i   in   5                   regfile write address
// - rf_wdata_i   in   XLEN                regfile write data
// - cfg_we_i     in   1                   write one check-list entry
// - cfg_idx_i    in   $clog2(NUM_CHECKS)  entry index
// - cfg_addr_i   in   5                   expected register number
// - cfg_data_i   in   XLEN                expected value
// - arm_i        in   1                   one-cycle pulse: start or restart monitoring
// - status_o     out  16                  {state[3:0], cur_idx[3:0], pass_cnt[7:0]}
// - done_o       out  1                   high in PASS or any FAIL state
// - pass_o       out  1                   high in PASS only
// BEHAVIOUR
// - Reset: state=IDLE, cur_idx=0, pass_cnt=0, prescaler=0, kcnt=0, status_o=16'h0000,
//   done_o=0, pass_o=0. Check-list contents are cleared to addr=0, data=0.
// - State codes: IDLE=0, ARMED=1, PASS=2, FAIL_TIMEOUT=3, FAIL_MISMATCH=4.
// - cfg_we_i writes entry cfg_idx_i in any state except ARMED; it is ignored while ARMED.
//   An out-of-range index is ignored.
// - arm_i in any state: go to ARMED next cycle; clear cur_idx, pass_cnt, prescaler and kcnt.
//   arm_i takes priority over every other event in that cycle.
// - ARMED, match rule: a match occurs when rf_we_i=1, rf_waddr_i==exp_addr[cur_idx] and
//   rf_wdata_i==exp_data[cur_idx].
//   - On a match, cur_idx and pass_cnt increment on the next edge (one-cycle latency).
//   - If cur_idx was NUM_CHECKS-1, the state goes to PASS instead.
// - Entry with exp_addr==0 (x0 is never written): the entry auto-passes one cycle after it
//   becomes current.
// - Only the current entry is compared. Matches for later entries are not remembered, so
//   checks are strictly ordered.
// - Timeout: the prescaler counts 0..999; on wrap, kcnt increments. When kcnt reaches
//   TIMEOUT_KCYC the state goes to FAIL_TIMEOUT. The timeout never fires when
//   TIMEOUT_KCYC=0.
// - Final match and timeout in the same cycle: PASS wins.
// - PASS and FAIL states are sticky until arm_i or reset. rf_* inputs are ignored outside ARMED.
// - status_o, done_o and pass_o are registered and track the state in the same cycle the state
//   register updates.
// - Reset mid-operation returns everything to reset values with no residual count.
// CONFIGURATION
// - MONITOR_STRICT_EN defined (strict mode): in ARMED, a write with
//   rf_waddr_i==exp_addr[cur_idx] (nonzero) but rf_wdata_i!=exp_data[cur_idx] moves the state
//   to FAIL_MISMATCH next cycle. A correct value on the same cycle is impossible, so there is
//   no conflict.
// - MONITOR_STRICT_EN undefined: wrong-value writes are ignored and the monitor keeps waiting.
//   State code 4 is unreachable.
// TESTING
// - Load {(3,3)}, NUM_CHECKS=1, arm; write x3=3 at cycle 50.
//   Expect: status_o=16'h2101 at cycle 51, done_o=1, pass_o=1.
// - Load (1,5),(2,7),(3,3),(4,9); write x2=7 first, then x1=5, x2=7, x3=3, x4=9.
//   Expect: the early x2 write is ignored; pass_cnt reaches 4; PASS.
// - TIMEOUT_KCYC=2, arm, no writes.
//   Expect: FAIL_TIMEOUT exactly 2000 cycles after the arm edge; status_o[15:12]=3.
// - Strict build: expect x3=3, core writes x3=4.
//   Expect: FAIL_MISMATCH next cycle. Non-strict build: the monitor stays ARMED and later
//   passes on x3=3.
// - Assert arm_i while ARMED with pass_cnt=2.
//   Expect: pass_cnt=0, kcnt=0 next cycle. cfg_we_i during ARMED leaves entries unchanged.
// - Assert wb_rst_i mid-run and in PASS.
//   Expect: status_o=0, done_o=0, pass_o=0 the next cycle; entries cleared.

Source files
------------

// File: rtl/elpis_test_monitor.sv
// Self-check monitor: snoops core0 regfile write-back against an ordered (reg, value) list.
// Optional strict mode (wrong value on the expected register fails) via MONITOR_STRICT_EN.
module elpis_test_monitor #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NUM_CHECKS   = 4,
  parameter int unsigned TIMEOUT_KCYC = 100,
  // A one-entry list still gets a 1-bit index port so the port never has zero width
  localparam int unsigned IdxW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            rf_we_i,
  input  logic [4:0]      rf_waddr_i,
  input  logic [XLEN-1:0] rf_wdata_i,
  input  logic            cfg_we_i,
  input  logic [IdxW-1:0] cfg_idx_i,
  input  logic [4:0]      cfg_addr_i,
  input  logic [XLEN-1:0] cfg_data_i,
  input  logic            arm_i,
  output logic [15:0]     status_o,
  output logic            done_o,
  output logic            pass_o
);

  localparam logic [3:0] StIdle         = 4'd0;
  localparam logic [3:0] StArmed        = 4'd1;
  localparam logic [3:0] StPass         = 4'd2;
  localparam logic [3:0] StFailTimeout  = 4'd3;
  localparam logic [3:0] StFailMismatch = 4'd4;

  logic [3:0]      state_q, state_d;
  logic [3:0]      cur_idx_q, cur_idx_d;
  logic [7:0]      pass_cnt_q, pass_cnt_d;
  logic [9:0]      presc_q, presc_d;
  logic [31:0]     kcnt_q, kcnt_d;
  logic            done_q, pass_q;
  logic [4:0]      exp_addr_q [NUM_CHECKS];
  logic [XLEN-1:0] exp_data_q [NUM_CHECKS];

  logic [4:0]      cur_addr;
  logic [XLEN-1:0] cur_data;
  logic            is_last, hit, advance, wrong, timeout_hit;

  // Select the current entry by compare so an index past the list reads as zero
  always_comb begin
    cur_addr = '0;
    cur_data = '0;
    for (int i = 0; i < int'(NUM_CHECKS); i++) begin
      if (cur_idx_q == 4'(i)) begin
        cur_addr = exp_addr_q[i];
        cur_data = exp_data_q[i];
      end
    end
  end

  assign is_last = ({28'd0, cur_idx_q} == NUM_CHECKS - 32'd1);
  assign hit     = rf_we_i && (rf_waddr_i == cur_addr) && (rf_wdata_i == cur_data);
  // x0 is never written, so an x0 entry passes on its own
  assign advance = hit || (cur_addr == 5'd0);

`ifdef MONITOR_STRICT_EN
  assign wrong = rf_we_i && (cur_addr != 5'd0) && (rf_waddr_i == cur_addr) &&
                 (rf_wdata_i != cur_data);
`else
  assign wrong = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT_KCYC != 32'd0) && (presc_q == 10'd999) &&
                       (kcnt_q + 32'd1 == TIMEOUT_KCYC);

  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    pass_cnt_d = pass_cnt_q;
    presc_d    = presc_q;
    kcnt_d     = kcnt_q;
    if (arm_i) begin
      state_d    = StArmed;
      cur_idx_d  = '0;
      pass_cnt_d = '0;
      presc_d    = '0;
      kcnt_d     = '0;
    end else if (state_q == StArmed) begin
      if (presc_q == 10'd999) begin
        presc_d = '0;
        kcnt_d  = kcnt_q + 32'd1;
      end else begin
        presc_d = presc_q + 10'd1;
      end
      if (advance) begin
        cur_idx_d  = cur_idx_q + 4'd1;
        pass_cnt_d = pass_cnt_q + 8'd1;
      end
      // Final match beats a simultaneous timeout
      if (advance && is_last) begin
        state_d = StPass;
      end else if (wrong) begin
        state_d = StFailMismatch;
      end else if (timeout_hit) begin
        state_d = StFailTimeout;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      cur_idx_q  <= '0;
      pass_cnt_q <= '0;
      presc_q    <= '0;
      kcnt_q     <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      for (int i = 0; i < int'(NUM_CHECKS); i++) begin
        exp_addr_q[i] <= '0;
        exp_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      pass_cnt_q <= pass_cnt_d;
      presc_q    <= presc_d;
      kcnt_q     <= kcnt_d;
      done_q     <= (state_d == StPass) || (state_d == StFailTimeout) ||
                    (state_d == StFailMismatch);
      pass_q     <= (state_d == StPass);
      if (cfg_we_i && (state_q != StArmed)) begin
        for (int i = 0; i < int'(NUM_CHECKS); i++) begin
          if (cfg_idx_i == IdxW'(i)) begin
            exp_addr_q[i] <= cfg_addr_i;
            exp_data_q[i] <= cfg_data_i;
          end
        end
      end
    end
  end

  assign status_o = {state_q, cur_idx_q, pass_cnt_q};
  assign done_o   = done_q;
  assign pass_o   = pass_q;

endmodule
